// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and the
// data stage: one outstanding transaction, data priority with a fetch starvation guard.
module mem_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_DM_STREAK  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_if_req,
  input  logic [XLEN-1:0] i_if_addr,
  input  logic            i_if_flush,
  output logic            or_if_ack,
  output logic [XLEN-1:0] or_if_data,
  input  logic            i_dm_req,
  input  logic [XLEN-1:0] i_dm_addr,
  input  logic [XLEN-1:0] i_dm_data,
  input  logic [2:0]      i_dm_funct3,
  input  logic            i_dm_read_write,
  output logic            or_dm_ack,
  output logic [XLEN-1:0] or_dm_data,
  output logic            or_mem_req,
  output logic [XLEN-1:0] or_mem_addr,
  output logic [XLEN-1:0] or_mem_data,
  output logic [2:0]      or_mem_funct3,
  output logic            or_mem_read_write,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_data,
  output logic            or_timeout,
  output logic            or_grant_dm
);
  localparam int            SW         = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
  localparam logic [15:0]   TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DROP_IF} state_t;

  state_t          state_reg, state_next;
  logic [15:0]     tmo_cnt_reg, tmo_cnt_next;
  logic [SW-1:0]   dm_streak_reg, dm_streak_next;
  logic            if_ack_next, dm_ack_next, mem_req_next, mem_rw_next;
  logic            timeout_next, grant_dm_next;
  logic [XLEN-1:0] if_data_next, dm_data_next, mem_addr_next, mem_data_next;
  logic [2:0]      mem_funct3_next;

  // A requester still showing its ack pulse is ignored so it cannot be reissued.
  logic if_ok, dm_ok, grant_dm, grant_if, busy, tmo_hit;
  assign if_ok    = i_if_req && !or_if_ack && !i_if_flush;
  assign dm_ok    = i_dm_req && !or_dm_ack;
  assign grant_dm = (state_reg == IDLE) && dm_ok && !(if_ok && dm_streak_reg == STREAK_MAX);
  assign grant_if = (state_reg == IDLE) && if_ok && !grant_dm;
  assign busy     = (state_reg != IDLE);
  assign tmo_hit  = busy && !i_mem_ack && (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg         <= IDLE;
      tmo_cnt_reg       <= '0;
      dm_streak_reg     <= '0;
      or_if_ack         <= 1'b0;
      or_if_data        <= '0;
      or_dm_ack         <= 1'b0;
      or_dm_data        <= '0;
      or_mem_req        <= 1'b0;
      or_mem_addr       <= '0;
      or_mem_data       <= '0;
      or_mem_funct3     <= 3'b000;
      or_mem_read_write <= 1'b0;
      or_timeout        <= 1'b0;
      or_grant_dm       <= 1'b0;
    end else begin
      state_reg         <= state_next;
      tmo_cnt_reg       <= tmo_cnt_next;
      dm_streak_reg     <= dm_streak_next;
      or_if_ack         <= if_ack_next;
      or_if_data        <= if_data_next;
      or_dm_ack         <= dm_ack_next;
      or_dm_data        <= dm_data_next;
      or_mem_req        <= mem_req_next;
      or_mem_addr       <= mem_addr_next;
      or_mem_data       <= mem_data_next;
      or_mem_funct3     <= mem_funct3_next;
      or_mem_read_write <= mem_rw_next;
      or_timeout        <= timeout_next;
      or_grant_dm       <= grant_dm_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_dm)      state_next = BUSY_DM;
        else if (grant_if) state_next = BUSY_IF;
      end
      BUSY_IF: begin
        if (i_mem_ack || tmo_hit) state_next = IDLE;
        else if (i_if_flush)      state_next = DROP_IF;
      end
      default: begin
        if (i_mem_ack || tmo_hit) state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    if_ack_next     = 1'b0;
    dm_ack_next     = 1'b0;
    timeout_next    = 1'b0;
    if_data_next    = or_if_data;
    dm_data_next    = or_dm_data;
    mem_req_next    = or_mem_req;
    mem_addr_next   = or_mem_addr;
    mem_data_next   = or_mem_data;
    mem_funct3_next = or_mem_funct3;
    mem_rw_next     = or_mem_read_write;
    grant_dm_next   = or_grant_dm;
    tmo_cnt_next    = tmo_cnt_reg;

    if (!i_if_req)                                  dm_streak_next = '0;
    else if (grant_if)                              dm_streak_next = '0;
    else if (grant_dm && dm_streak_reg != STREAK_MAX) dm_streak_next = dm_streak_reg + 1'b1;
    else                                            dm_streak_next = dm_streak_reg;

    if (grant_dm) begin
      mem_req_next    = 1'b1;
      mem_addr_next   = i_dm_addr;
      mem_data_next   = i_dm_data;
      mem_funct3_next = i_dm_funct3;
      mem_rw_next     = i_dm_read_write;
      grant_dm_next   = 1'b1;
      tmo_cnt_next    = '0;
    end else if (grant_if) begin
      mem_req_next    = 1'b1;
      mem_addr_next   = i_if_addr;
      mem_data_next   = '0;
      mem_funct3_next = 3'b010;
      mem_rw_next     = 1'b0;
      grant_dm_next   = 1'b0;
      tmo_cnt_next    = '0;
    end else if (busy) begin
      // A same-edge ack beats the timeout; a flushed fetch never reports back.
      if (i_mem_ack || tmo_hit) begin
        mem_req_next = 1'b0;
        timeout_next = !i_mem_ack;
        if (state_reg == BUSY_DM) begin
          dm_ack_next  = 1'b1;
          dm_data_next = (i_mem_ack && !or_mem_read_write) ? i_mem_data : '0;
        end else if (state_reg == BUSY_IF && !i_if_flush) begin
          if_ack_next  = 1'b1;
          if_data_next = i_mem_ack ? i_mem_data : '0;
        end
      end else begin
        tmo_cnt_next = tmo_cnt_reg + 16'd1;
      end
    end
  end
endmodule
